rv32i_load_writeback: RTL and testbench

RV32I_LOAD_WRITEBACK -- requirements
Module: rv32i_load_writeback

---
 rtl/rv32i_pkg.sv | 32 +++
 rtl/rv32i_load_align.sv | 45 ++++
 rtl/rv32i_load_writeback.sv | 162 ++++++++++++++++
 tb/tb_rv32i_load_writeback.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I load/writeback slice.
//   - funct3 encodings of the integer load instructions (LB, LH, LW, LBU, LHU)
//   - writeback FSM state enum
//   - misaligned-load predicate used when RV32I_LOAD_MISALIGN_CHECK_EN is defined
package rv32i_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StWrite
  } wb_state_e;

  // Unlisted funct3 codes are handled as LW, so they need word alignment too.
  function automatic logic load_is_misaligned(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      Funct3Lb, Funct3Lbu: mis = 1'b0;
      Funct3Lh, Funct3Lhu: mis = addr_lo[0];
      default:             mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   funct3_i  - load width/sign encoding
//   addr_lo_i - byte offset of the load address within the word
//   word_i    - aligned 32-bit word returned by data memory
//   result_o  - value to write back to the register file
// LB/LBU pick byte addr_lo_i, LH/LHU pick half addr_lo_i[1], everything else is a full word.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // Half-word lane ignores addr_lo_i[0]; a misaligned LH just reads the containing half.
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    result_o = word_i;
    case (funct3_i)
      Funct3Lb:  result_o = {{24{byte_sel[7]}}, byte_sel};
      Funct3Lbu: result_o = {24'h000000, byte_sel};
      Funct3Lh:  result_o = {{16{half_sel[15]}}, half_sel};
      Funct3Lhu: result_o = {16'h0000, half_sel};
      default:   result_o = word_i;
    endcase
  end

endmodule

// File: rtl/rv32i_load_writeback.sv
// RV32I load/writeback stage: accepts one op at a time from execute, issues data-memory reads
// for loads, aligns/extends the returned word and writes the result to the register file.
// Ports:
//   clk, rst                       - clock (rising edge), synchronous active-high reset
//   in_valid/in_ready              - op handshake; in_ready only while idle
//   in_is_load, in_funct3, in_rd,
//   in_result                      - load flag, load type, destination, ALU result or load address
//   mem_req/mem_addr/mem_gnt       - word-aligned read request, held until granted
//   mem_rvalid/mem_rdata           - read data return
//   wr_enable/wr_addr/wr_data      - register-file write port (never enabled for rd == 0)
//   load_misaligned                - one-cycle flag for a rejected misaligned load
// Optional feature macro: RV32I_LOAD_MISALIGN_CHECK_EN enables misalignment detection; when
// undefined, load_misaligned is tied low and misaligned loads use the lane rules as-is.
// All outputs come straight from flops.
module rv32i_load_writeback
  import rv32i_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned NUM_OF_SETS    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_is_load,
  input  logic [2:0]                     in_funct3,
  input  logic [$clog2(NUM_OF_SETS)-1:0] in_rd,
  input  logic [DATA_BUS_WIDTH-1:0]      in_result,
  output logic                           mem_req,
  output logic [DATA_BUS_WIDTH-1:0]      mem_addr,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  input  logic [DATA_BUS_WIDTH-1:0]      mem_rdata,
  output logic                           wr_enable,
  output logic [$clog2(NUM_OF_SETS)-1:0] wr_addr,
  output logic [DATA_BUS_WIDTH-1:0]      wr_data,
  output logic                           load_misaligned
);

  localparam int unsigned AddrW = $clog2(NUM_OF_SETS);

  wb_state_e                 state_q, state_d;
  logic [2:0]                funct3_q, funct3_d;
  logic [1:0]                addr_lo_q, addr_lo_d;
  logic                      in_ready_q, in_ready_d;
  logic                      mem_req_q, mem_req_d;
  logic [DATA_BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      wr_enable_q, wr_enable_d;
  logic [AddrW-1:0]          wr_addr_q, wr_addr_d;
  logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [31:0]               load_value;
  logic                      acc_misaligned;

  rv32i_load_align u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .word_i    (mem_rdata),
    .result_o  (load_value)
  );

`ifdef RV32I_LOAD_MISALIGN_CHECK_EN
  logic misaligned_q;

  assign acc_misaligned = in_is_load && load_is_misaligned(in_funct3, in_result[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= (state_q == StIdle) && in_valid && acc_misaligned;
    end
  end

  assign load_misaligned = misaligned_q;
`else
  assign acc_misaligned  = 1'b0;
  assign load_misaligned = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    mem_addr_d = mem_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!in_is_load) begin
            wr_addr_d = in_rd;
            wr_data_d = in_result;
            state_d   = StWrite;
          end else if (!acc_misaligned) begin
            wr_addr_d  = in_rd;
            funct3_d   = in_funct3;
            addr_lo_d  = in_result[1:0];
            mem_addr_d = {in_result[DATA_BUS_WIDTH-1:2], 2'b00};
            state_d    = StReq;
          end
          // A rejected misaligned load leaves the stage idle.
        end
      end
      StReq: begin
        if (mem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          wr_data_d = load_value;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered images of the state being entered.
    in_ready_d  = (state_d == StIdle);
    mem_req_d   = (state_d == StReq);
    wr_enable_d = (state_d == StWrite) && (wr_addr_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      in_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      wr_enable_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      in_ready_q  <= in_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      wr_enable_q <= wr_enable_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign wr_enable = wr_enable_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_rv32i_load_writeback.sv
// Self-checking bench for rv32i_load_writeback: directed ops, a transaction-level write
// scoreboard checked every cycle, and literal expectations for the named scenarios.
module tb_rv32i_load_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        load_misaligned;

  always #5 clk = ~clk;

  rv32i_load_writeback #(
    .DATA_BUS_WIDTH (32),
    .NUM_OF_SETS    (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_is_load      (in_is_load),
    .in_funct3       (in_funct3),
    .in_rd           (in_rd),
    .in_result       (in_result),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .wr_enable       (wr_enable),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .load_misaligned (load_misaligned)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          last_wr_cyc = 0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] exp_mem_addr = '0;
  bit          req_ok = 1'b0;
  bit          mis_ok = 1'b0;
  wr_t         exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  // Architectural load result: shift the lane down, mask, and sign-extend by subtraction.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] v;
    int unsigned off;
    case (f3)
      3'd0, 3'd4: begin
        off = 8 * int'(addr[1:0]);
        v = (w >> off) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      3'd1, 3'd5: begin
        off = 16 * int'(addr[1]);
        v = (w >> off) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Compare process: every write must match the scoreboard; requests and flags must be expected.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (!rst) begin
      if (wr_enable) begin
        if (exp_q.size() == 0) begin
          fail_evt("unexpected_write");
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", {27'd0, wr_addr}, {27'd0, w.a});
          chk("wr_data", wr_data, w.d);
        end
        wr_count++;
        last_wr_cyc  = cyc;
        last_wr_data = wr_data;
      end
      if (mem_req) begin
        last_req_addr = mem_addr;
        if (!req_ok) fail_evt("unexpected_mem_req");
        else chk("mem_addr_stable", mem_addr, exp_mem_addr);
      end
      if (load_misaligned && !mis_ok) fail_evt("unexpected_load_misaligned");
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: in_ready=%b, required 1 within 50 cycles", tag, in_ready);
    end
  endtask

  task automatic do_op(input string tag, input bit is_load, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rdata,
                       input int gnt_dly, input int rv_dly, input bit mis);
    int wc0;
    int acc;
    int lat;
    int exp_writes;
    wait_ready(tag);
    wc0 = wr_count;
    lat = 1;
    exp_writes = 0;
    if (!is_load) begin
      if (rd != 0) begin
        exp_q.push_back('{a: rd, d: res});
        exp_writes = 1;
      end
    end else if (!mis) begin
      if (rd != 0) begin
        exp_q.push_back('{a: rd, d: ref_load(f3, res, rdata)});
        exp_writes = 1;
      end
      exp_mem_addr = res & ~32'h3;
      req_ok = 1'b1;
      lat = 3 + gnt_dly + rv_dly;
    end else begin
      mis_ok = 1'b1;
    end
    in_valid = 1'b1;
    in_is_load = is_load;
    in_funct3 = f3;
    in_rd = rd;
    in_result = res;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc - 1;
    chk({tag, "_in_ready_after_accept"}, {31'd0, in_ready}, {31'd0, mis});
    if (is_load && mis) begin
      chk({tag, "_misaligned_pulse"}, {31'd0, load_misaligned}, 32'd1);
      chk({tag, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_misaligned_drop"}, {31'd0, load_misaligned}, 32'd0);
      mis_ok = 1'b0;
    end else if (is_load) begin
      chk({tag, "_mem_req_issued"}, {31'd0, mem_req}, 32'd1);
      // Stray read data while the request is pending must be ignored.
      for (int i = 0; i < gnt_dly; i++) begin
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A5A_0000 | i;
        @(posedge clk);
        #1;
        chk({tag, "_mem_req_held"}, {31'd0, mem_req}, 32'd1);
      end
      mem_rvalid = 1'b0;
      mem_gnt = 1'b1;
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      req_ok = 1'b0;
      chk({tag, "_mem_req_dropped"}, {31'd0, mem_req}, 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
        @(posedge clk);
        #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
    end
    wait_ready(tag);
    chk({tag, "_write_count"}, wr_count - wc0, exp_writes);
    if (exp_writes == 1) chk({tag, "_latency"}, last_wr_cyc - acc, lat);
    chk({tag, "_scoreboard_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int wc0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_is_load = 1'b0;
    in_funct3 = 3'd0;
    in_rd = 5'd0;
    in_result = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_wr_enable", {31'd0, wr_enable}, 32'd0);
    chk("reset_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    chk("reset_load_misaligned", {31'd0, load_misaligned}, 32'd0);

    // ALU writeback, one cycle after acceptance.
    do_op("alu_rd5", 1'b0, 3'd0, 5'd5, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);
    chk("alu_rd5_literal", last_wr_data, 32'hDEADBEEF);

    // Byte loads from lane 3, minimum latency.
    do_op("lb_103", 1'b1, 3'd0, 5'd1, 32'h0000_0103, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lb_103_literal", last_wr_data, 32'hFFFF_FF80);
    chk("lb_103_mem_addr", last_req_addr, 32'h0000_0100);
    do_op("lbu_103", 1'b1, 3'd4, 5'd2, 32'h0000_0103, 32'h80FF_1234, 0, 0, 1'b0);
    chk("lbu_103_literal", last_wr_data, 32'h0000_0080);

    // Half load with a late grant.
    do_op("lh_202", 1'b1, 3'd1, 5'd3, 32'h0000_0202, 32'h8001_7FFF, 4, 0, 1'b0);
    chk("lh_202_literal", last_wr_data, 32'hFFFF_8001);
    chk("lh_202_mem_addr", last_req_addr, 32'h0000_0200);

    do_op("lhu_200", 1'b1, 3'd5, 5'd7, 32'h0000_0200, 32'h8001_7FFF, 1, 2, 1'b0);
    chk("lhu_200_literal", last_wr_data, 32'h0000_7FFF);
    do_op("lh_200_pos", 1'b1, 3'd1, 5'd8, 32'h0000_0200, 32'h1234_F00D, 0, 1, 1'b0);
    chk("lh_200_literal", last_wr_data, 32'hFFFF_F00D);
    do_op("lw_300", 1'b1, 3'd2, 5'd31, 32'h0000_0300, 32'h1234_5678, 0, 0, 1'b0);
    chk("lw_300_literal", last_wr_data, 32'h1234_5678);
    do_op("f3_011_as_lw", 1'b1, 3'd3, 5'd10, 32'h0000_0304, 32'h8765_4321, 0, 0, 1'b0);
    do_op("f3_110_as_lw", 1'b1, 3'd6, 5'd11, 32'h0000_0308, 32'hA5A5_5A5A, 0, 0, 1'b0);

    // Remaining byte lanes.
    do_op("lb_lane0", 1'b1, 3'd0, 5'd12, 32'h0000_0400, 32'h1122_33F4, 0, 0, 1'b0);
    chk("lb_lane0_literal", last_wr_data, 32'hFFFF_FFF4);
    do_op("lb_lane1", 1'b1, 3'd0, 5'd13, 32'h0000_0401, 32'h1122_33F4, 0, 0, 1'b0);
    chk("lb_lane1_literal", last_wr_data, 32'h0000_0033);
    do_op("lbu_lane2", 1'b1, 3'd4, 5'd14, 32'h0000_0402, 32'h11A2_33F4, 1, 1, 1'b0);
    chk("lbu_lane2_literal", last_wr_data, 32'h0000_00A2);

    // Destination x0: request still issued, no write.
    do_op("load_rd0", 1'b1, 3'd2, 5'd0, 32'h0000_0500, 32'hFFFF_FFFF, 0, 0, 1'b0);
    chk("load_rd0_mem_addr", last_req_addr, 32'h0000_0500);
    do_op("alu_rd0", 1'b0, 3'd0, 5'd0, 32'h1234_0000, 32'h0, 0, 0, 1'b0);

    // Stray grant/read data while idle are ignored.
    wc0 = wr_count;
    mem_gnt = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk("idle_stray_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_stray_mem_req", {31'd0, mem_req}, 32'd0);
    chk("idle_stray_no_write", wr_count - wc0, 32'd0);

    // Reset while waiting for read data drops the load.
    wait_ready("rst_wait");
    wc0 = wr_count;
    exp_mem_addr = 32'h0000_0600;
    req_ok = 1'b1;
    in_valid = 1'b1;
    in_is_load = 1'b1;
    in_funct3 = 3'd2;
    in_rd = 5'd9;
    in_result = 32'h0000_0600;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    req_ok = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wait_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wait_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wait_mem_addr", mem_addr, 32'd0);
    chk("rst_wait_wr_enable", {31'd0, wr_enable}, 32'd0);
    chk("rst_wait_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wait_wr_data", wr_data, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_CAFE;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_wait_no_write", wr_count - wc0, 32'd0);
    chk("rst_wait_ready_after", {31'd0, in_ready}, 32'd1);

    // Misaligned word load.
`ifdef RV32I_LOAD_MISALIGN_CHECK_EN
    do_op("lw_mis_101", 1'b1, 3'd2, 5'd6, 32'h0000_0101, 32'hCAFE_F00D, 0, 0, 1'b1);
    do_op("lh_mis_203", 1'b1, 3'd5, 5'd6, 32'h0000_0203, 32'hCAFE_F00D, 0, 0, 1'b1);
`else
    do_op("lw_mis_101", 1'b1, 3'd2, 5'd6, 32'h0000_0101, 32'hCAFE_F00D, 0, 0, 1'b0);
    chk("lw_mis_101_mem_addr", last_req_addr, 32'h0000_0100);
    chk("lw_mis_101_literal", last_wr_data, 32'hCAFE_F00D);
    chk("lw_mis_flag_low", {31'd0, load_misaligned}, 32'd0);
`endif

    // Back-to-back ALU op after a load.
    do_op("alu_rd20", 1'b0, 3'd0, 5'd20, 32'h0000_0001, 32'h0, 0, 0, 1'b0);
    chk("alu_rd20_literal", last_wr_data, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
